// File: rtl/obj_code_extender.sv
// obj_code_extender: widens sprite tile codes via a CPU-writable extension RAM indexed by sprite number.
// Latency: request in cycle N -> code_valid/code_modified in N+2; one request per cycle, no stalls.
// Backpressure: none; the pipeline always accepts code_req, CPU port is single-cycle.
// Ports: clk/reset; mode selects passthrough / low-lane ext / high-lane ext / chain;
//        cs, cpu_addr, cpu_ds_n, cpu_rw, din, dout form the CPU port to the extension RAM;
//        code_req, code_original, code_chain, obj_addr in; code_modified, code_valid out.
module obj_code_extender #(
    parameter int CODE_IN_W   = 13,
    parameter int KEEP_W      = 8,
    parameter int EXT_W       = 8,
    parameter int CODE_OUT_W  = 19,
    parameter int IDX_W       = 12,
    parameter int ENTRY_SHIFT = 3,
    parameter int OBJ_ADDR_W  = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic                  cs,
    input  logic [IDX_W-1:0]      cpu_addr,
    input  logic [1:0]            cpu_ds_n,
    input  logic                  cpu_rw,
    input  logic [15:0]           din,
    output logic [15:0]           dout,
    input  logic                  code_req,
    input  logic [CODE_IN_W-1:0]  code_original,
    input  logic                  code_chain,
    input  logic [OBJ_ADDR_W-1:0] obj_addr,
    output logic [CODE_OUT_W-1:0] code_modified,
    output logic                  code_valid
);

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_EXT_LO = 2'd1,
        MODE_EXT_HI = 2'd2,
        MODE_CHAIN  = 2'd3
    } mode_e;

    if (CODE_OUT_W < KEEP_W + EXT_W || CODE_OUT_W < CODE_IN_W) begin : g_bad_out_w
        $error("obj_code_extender: CODE_OUT_W too narrow");
    end
    if (OBJ_ADDR_W < ENTRY_SHIFT + IDX_W) begin : g_bad_obj_w
        $error("obj_code_extender: OBJ_ADDR_W too narrow for index");
    end
    if (KEEP_W > CODE_IN_W) begin : g_bad_keep_w
        $error("obj_code_extender: KEEP_W exceeds CODE_IN_W");
    end

    logic [EXT_W-1:0] ext_ram [2**IDX_W];

    // CPU port: byte lane follows the high-lane mode so the CPU can use whichever
    // half of the bus its sprite table layout expects.
    logic             wr_en;
    logic [7:0]       wr_lane;
    logic [EXT_W-1:0] wr_dat;
    logic [7:0]       rd_byte;

    always_comb begin
        wr_en   = 1'b0;
        wr_lane = din[7:0];
        if (mode_e'(mode) == MODE_EXT_HI) begin
            wr_lane = din[15:8];
            wr_en   = cs & ~cpu_rw & ~cpu_ds_n[1];
        end else begin
            wr_en   = cs & ~cpu_rw & ~cpu_ds_n[0];
        end
        wr_dat  = EXT_W'(wr_lane);
        rd_byte = 8'(ext_ram[cpu_addr]);
    end

    // Lookup read is registered alongside stage 1; being a non-blocking read it
    // returns the pre-write value when the CPU writes the same entry that cycle.
    logic [IDX_W-1:0] lookup_idx;
    logic [EXT_W-1:0] ext_q;

    assign lookup_idx = obj_addr[ENTRY_SHIFT+IDX_W-1:ENTRY_SHIFT];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ext_ram[cpu_addr] <= wr_dat;
        end
        ext_q <= ext_ram[lookup_idx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= '0;
        end else if (cs & cpu_rw) begin
            dout <= {rd_byte, rd_byte};
        end
    end

    // Stage 1 registers
    logic                 s1_vld;
    logic [CODE_IN_W-1:0] s1_code;
    logic                 s1_chain;
    mode_e                s1_mode;
    logic [EXT_W-1:0]     chain_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld   <= 1'b0;
            s1_code  <= '0;
            s1_chain <= 1'b0;
            s1_mode  <= MODE_PASS;
        end else begin
            s1_vld <= code_req;
            if (code_req) begin
                s1_code  <= code_original;
                s1_chain <= code_chain;
                s1_mode  <= mode_e'(mode);
            end
        end
    end

    // Stage 2: form the widened code
    logic [EXT_W-1:0]      ext_sel;
    logic [EXT_W-1:0]      chain_nxt;
    logic [CODE_OUT_W-1:0] result;

    always_comb begin
        ext_sel   = ext_q;
        chain_nxt = chain_q;
        result    = '0;
        case (s1_mode)
            MODE_PASS: begin
                result = CODE_OUT_W'(s1_code);
            end
            MODE_EXT_LO, MODE_EXT_HI: begin
                result = CODE_OUT_W'({ext_q, s1_code[KEEP_W-1:0]});
            end
            default: begin
                // Chain head refreshes the latch; continuations ignore the RAM.
                if (s1_chain) begin
                    ext_sel = chain_q;
                end else begin
                    chain_nxt = ext_q;
                end
                result = CODE_OUT_W'({ext_sel, s1_code[KEEP_W-1:0]});
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_modified <= '0;
            code_valid    <= 1'b0;
            chain_q       <= '0;
        end else begin
            code_valid <= s1_vld;
            if (s1_vld) begin
                code_modified <= result;
                chain_q       <= chain_nxt;
            end
        end
    end

    // Only the index field of obj_addr matters; remaining bits are intentionally dropped.
    logic unused_obj_bits;
    assign unused_obj_bits = ^obj_addr;

endmodule

// File: tb/tb_obj_code_extender.sv
module tb_obj_code_extender;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = '0;
    logic        cs = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [1:0]  cpu_ds_n = 2'b11;
    logic        cpu_rw = 1'b1;
    logic [15:0] din = '0;
    logic [15:0] dout;
    logic        code_req = 1'b0;
    logic [12:0] code_original = '0;
    logic        code_chain = 1'b0;
    logic [14:0] obj_addr = '0;
    logic [18:0] code_modified;
    logic        code_valid;

    obj_code_extender dut (
        .clk(clk), .reset(reset), .mode(mode), .cs(cs), .cpu_addr(cpu_addr),
        .cpu_ds_n(cpu_ds_n), .cpu_rw(cpu_rw), .din(din), .dout(dout),
        .code_req(code_req), .code_original(code_original), .code_chain(code_chain),
        .obj_addr(obj_addr), .code_modified(code_modified), .code_valid(code_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] code;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [7:0]  mram [4096];
    logic [7:0]  chain_m = 8'h00;
    logic [18:0] last_exp = '0;
    logic [15:0] exp_dout = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes code_valid.
    always @(negedge clk) begin
        if (reset) begin
            chk("reset_valid", 32'(code_valid), 32'd0);
            chk("reset_code", 32'(code_modified), 32'd0);
            chk("reset_dout", 32'(dout), 32'd0);
        end else begin
            if (code_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("code", 32'(code_modified), 32'(e.code));
                    chk("latency", cyc, e.cyc);
                    last_exp = e.code;
                end
            end else begin
                chk("hold", 32'(code_modified), 32'(last_exp));
            end
            chk("dout", 32'(dout), 32'(exp_dout));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle of inputs and updates the reference model from the rules.
    task automatic drive(input bit req, input logic [14:0] oa, input logic [12:0] code,
                         input bit ch, input logic [1:0] md, input bit cs_i, input bit rw_i,
                         input logic [11:0] a, input logic [1:0] ds, input logic [15:0] d);
        logic [7:0]  e;
        logic [18:0] x;
        bit          rd_pend;
        logic [15:0] rd_val;
        code_req = req; obj_addr = oa; code_original = code; code_chain = ch;
        mode = md; cs = cs_i; cpu_rw = rw_i; cpu_addr = a; cpu_ds_n = ds; din = d;
        rd_pend = 1'b0;
        rd_val  = '0;
        if (req) begin
            e = mram[oa / 8];
            if (md == 2'd0) begin
                x = 19'(code);
            end else if (md == 2'd3 && ch) begin
                x = 19'(chain_m) * 256 + 19'(code % 256);
            end else begin
                if (md == 2'd3) chain_m = e;
                x = 19'(e) * 256 + 19'(code % 256);
            end
            sb_q.push_back('{code: x, cyc: cyc + 2});
        end
        if (cs_i && rw_i) begin
            rd_pend = 1'b1;
            rd_val  = {mram[a], mram[a]};
        end
        if (cs_i && !rw_i) begin
            if (md == 2'd2) begin
                if (!ds[1]) mram[a] = d[15:8];
            end else if (!ds[0]) begin
                mram[a] = d[7:0];
            end
        end
        step();
        if (rd_pend) exp_dout = rd_val;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, '0, 0, 2'd0, 0, 1, '0, 2'b11, '0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] v);
        drive(0, '0, '0, 0, 2'd1, 1, 0, a, 2'b10, {8'h00, v});
    endtask

    task automatic look(input logic [14:0] oa, input logic [12:0] code, input bit ch,
                        input logic [1:0] md);
        drive(1, oa, code, ch, md, 0, 1, '0, 2'b11, '0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Fill the whole extension RAM so every lookup has a known value.
        for (int i = 0; i < 4096; i++) wr(12'(i), 8'($urandom));

        // Mode 0 passthrough
        look(15'h0000, 13'h1ABC, 0, 2'd0);
        idle(2);

        // Mode 1: low lane write, lookup, CPU read
        drive(0, '0, '0, 0, 2'd1, 1, 0, 12'h012, 2'b10, 16'h0055);
        look(15'h0090, 13'h0123, 0, 2'd1);
        drive(0, '0, '0, 0, 2'd1, 1, 1, 12'h012, 2'b11, 16'h0000);
        idle(2);

        // Mode 2: high lane write; low-lane-only write ignored
        drive(0, '0, '0, 0, 2'd2, 1, 0, 12'h001, 2'b01, 16'hA700);
        drive(0, '0, '0, 0, 2'd2, 1, 0, 12'h001, 2'b10, 16'h00BB);
        look(15'h0008, 13'h00FF, 0, 2'd2);
        idle(2);

        // Mode 3 chain: head, continuation, new head back-to-back
        wr(12'd3, 8'h11);
        wr(12'd4, 8'h22);
        look(15'h0018, 13'h0034, 0, 2'd3);
        look(15'h0020, 13'h0056, 1, 2'd3);
        look(15'h0020, 13'h0078, 0, 2'd3);
        idle(2);

        // Same-cycle write and lookup on entry 5
        wr(12'd5, 8'h33);
        drive(1, 15'h0028, 13'h0011, 0, 2'd1, 1, 0, 12'd5, 2'b10, 16'h0077);
        look(15'h0028, 13'h0022, 0, 2'd1);
        idle(2);

        // Index wrap: last entry and entry 0 are independent
        wr(12'hFFF, 8'hEE);
        wr(12'h000, 8'h01);
        look(15'h7FF8, 13'h0001, 0, 2'd1);
        look(15'h0007, 13'h0002, 0, 2'd1);
        idle(2);

        // Reset the cycle after a request: the request is discarded
        look(15'h0000, 13'h0ABC, 0, 2'd0);
        reset = 1'b1;
        code_req = 1'b0;
        sb_q.delete();
        chain_m = 8'h00;
        last_exp = '0;
        exp_dout = '0;
        step();
        step();
        reset = 1'b0;
        idle(2);
        look(15'h0018, 13'h0045, 1, 2'd3);
        look(15'h0000, 13'h0BCD, 0, 2'd0);
        idle(2);

        // CPU write without lane strobe, then read back
        drive(0, '0, '0, 0, 2'd1, 1, 0, 12'h012, 2'b11, 16'h00CC);
        drive(0, '0, '0, 0, 2'd1, 1, 1, 12'h012, 2'b11, 16'h0000);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] sel;
            sel = 3'($urandom_range(0, 7));
            drive(bit'($urandom_range(0, 3) != 0), 15'($urandom), 13'($urandom),
                  bit'($urandom), 2'($urandom), bit'(sel < 3), bit'(sel == 0),
                  ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 15)) : 12'($urandom),
                  2'($urandom), 16'($urandom));
        end

        idle(4);
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("missing_valid", 32'd0, 32'(e.code));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/obj_code_extender.md
# obj_code_extender

Parametrised sprite tile-code extender between the sprite engine's object-RAM fetch and the graphics-ROM address path. It holds a CPU-writable extension RAM indexed by sprite number and widens each fetched tile code to a larger ROM code space. Supports passthrough, two byte-lane extension modes and a chain mode in which continuation sprites inherit the extension of their chain head. Lookups run as a fixed 2-cycle, one-per-cycle pipeline with an explicit valid strobe.

## Interface
Parameters:
- CODE_IN_W, 13, width of the tile code from object RAM
- KEEP_W, 8, low code bits passed through unchanged in extension modes
- EXT_W, 8, extension RAM data width
- CODE_OUT_W, 19, output code width; must be >= KEEP_W+EXT_W and >= CODE_IN_W (elaboration error otherwise)
- IDX_W, 12, log2 of extension RAM entries; also CPU address width
- ENTRY_SHIFT, 3, log2 of object-RAM words per sprite entry
- OBJ_ADDR_W, 15, object-RAM word address width; must be >= ENTRY_SHIFT+IDX_W

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mode  in  2  0 passthrough, 1 extend/low byte lane, 2 extend/high byte lane, 3 chain
- cs  in  1  CPU select for extension RAM
- cpu_addr  in  IDX_W  CPU entry address
- cpu_ds_n  in  2  data strobes, active low ([1] high byte, [0] low byte)
- cpu_rw  in  1  1 read, 0 write
- din  in  16  CPU write data
- dout  out  16  CPU read data, byte replicated on both lanes
- code_req  in  1  lookup request strobe
- code_original  in  CODE_IN_W  fetched tile code
- code_chain  in  1  sprite is a chain continuation (used in mode 3 only)
- obj_addr  in  OBJ_ADDR_W  object-RAM address of the sprite entry
- code_modified  out  CODE_OUT_W  extended code
- code_valid  out  1  one-cycle strobe, code_modified valid

## Operation
- Extension RAM: 2^IDX_W x EXT_W, dual port; lookup port read-only, CPU port read/write.
- CPU write: cs & ~cpu_rw & lane strobe active; lane = ds_n[1]/din[15:8] in mode 2, ds_n[0]/din[7:0] otherwise; written bits = din lane zero-extended or truncated to EXT_W.
- CPU read: dout = {ram_byte, ram_byte} registered one cycle after cs & cpu_rw; EXT_W < 8 zero-extends; holds value otherwise.
- Lookup index = obj_addr[ENTRY_SHIFT+IDX_W-1:ENTRY_SHIFT].
- Stage 1 (request cycle N): register index, code_original, code_chain, mode; issue RAM read.
- Stage 2 (N+1): form result:
  - mode 0: zero-extend code_original to CODE_OUT_W.
  - mode 1/2: {zeros, ext, code_original[KEEP_W-1:0]}.
  - mode 3: code_chain=0 → use ext, load chain latch with ext; code_chain=1 → use chain latch, RAM value ignored.
- Result and code_valid registered at end of N+1, visible cycle N+2.
- Mode is sampled per request at stage 1; a mode change affects only later requests.

## Timing
- Reset values: code_modified=0, code_valid=0, dout=0, chain latch=0, pipeline valids=0.
- Latency: request cycle N → code_valid high exactly in N+2, for one cycle per request.
- Throughput: one request per cycle; back-to-back requests produce back-to-back valids in order.
- code_modified holds last result when no valid.
- CPU write and lookup to the same entry in the same cycle: lookup returns the pre-write value; the write lands.
- Chain continuation with no prior head since reset: uses latch value 0.
- Index wrap: higher obj_addr bits ignored; entry 2^IDX_W-1 and entry 0 are independent.
- Reset asserted mid-flight: in-flight requests are discarded; no code_valid before a new post-reset request.
- CPU access without a lane strobe: no write; read still returns data.

## Test plan
- Reset then mode 0, code_req with code_original=0x1ABC → cycle+2 code_valid=1, code_modified=0x01ABC.
- Mode 1: CPU write din=0x0055 to addr 0x012 (ds_n=2'b10); request obj_addr=0x0090, code 0x0123 → 0x05523; CPU read addr 0x012 → dout=0x5555 next cycle.
- Mode 2: write din=0xA700, ds_n=2'b01 to addr 0x001; request obj_addr=0x0008, code 0x00FF → 0x0A7FF; a low-lane-only write is ignored.
- Mode 3: entries 3=0x11, 4=0x22; requests obj 0x18 chain=0, obj 0x20 chain=1, obj 0x20 chain=0 on consecutive cycles → 0x011xx, 0x011xx, 0x022xx in three consecutive cycles.
- Same-cycle CPU write 0x77 and lookup on entry 5 (old 0x33) → lookup returns 0x33; next lookup returns 0x77.
- Assert reset the cycle after code_req → no code_valid; outputs 0; next request completes normally at +2.
